fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the in-order pipeline, directly upstream of the hazard control logic and the decode stage. Owns the fetch PC, issues single-outstanding requests to the instruction memory, and fills the IF/ID pipeline register. Obeys the IF-stage stall and flush controls and the EX-stage branch redirect. Absorbs a late memory response during a stall in a one-entry hold buffer.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID when invalid (addi x0,x0,0)

- iClk  in  1  clock; all state updates on rising edge
- iRst  in  1  reset, synchronous, active-high
- iStall  in  1  hold IF/ID register (driven by hazard unit IF stall)
- iFlush  in  1  invalidate IF/ID register (driven by hazard unit IF reset)
- iBrTrue  in  1  redirect fetch to iBrTarget this cycle
- iBrTarget  in  XLEN  redirect address; bits [1:0] ignored (treated as 0)
- oImemReq  out  1  fetch request valid
- oImemAddr  out  XLEN  fetch address, word aligned
- iImemGnt  in  1  request accepted this cycle (meaningful only with oImemReq)
- iImemRvalid  in  1  response valid; exactly one per granted request, ≥1 cycle after grant
- iImemRdata  in  32  response instruction word
- oIF_ID_valid  out  1  IF/ID holds a real instruction
- oIF_ID_pc  out  XLEN  PC of IF/ID instruction
- oIF_ID_pc4  out  XLEN  oIF_ID_pc + 4
- oIF_ID_instr  out  32  instruction word
- oBusy  out  1  a request is outstanding (state WAIT)

## Operation
- Registers: state, fetchPc (next address to request), reqPc (address of outstanding request), kill flag, hold buffer (pc, instr), IF/ID register.
- States: REQ (may issue), WAIT (one request outstanding), HOLD (response buffered, IF/ID stalled).
- oImemReq = !iBrTrue && (state==REQ || (state==WAIT && iImemRvalid && !kill && !iStall)); oImemAddr = fetchPc. Address stable while oImemReq high and not granted.
- Grant: reqPc <= fetchPc; fetchPc <= fetchPc + 4 (wraps mod 2^XLEN); state -> WAIT.
- WAIT, iImemRvalid, kill=1: drop response, kill <= 0, -> REQ.
- WAIT, iImemRvalid, kill=0, !iStall: deliver (reqPc, iImemRdata) to IF/ID; -> WAIT if new grant same cycle (issue-on-retire), else REQ.
- WAIT, iImemRvalid, kill=0, iStall: capture into hold buffer, -> HOLD. No request in HOLD.
- HOLD, !iStall: deliver hold buffer to IF/ID, -> REQ.
- Redirect (iBrTrue, any state, regardless of iStall): fetchPc <= {iBrTarget[XLEN-1:2],2'b00}; hold buffer discarded; REQ->REQ, HOLD->REQ; WAIT with iImemRvalid same cycle -> response dropped, -> REQ; WAIT without iImemRvalid -> kill <= 1, stay WAIT. kill already 1 stays 1.
- IF/ID update priority: iRst > iFlush > iStall > deliver > bubble. Flush/bubble: valid=0, instr=NOP_INSTR, pc/pc4 hold. Stall: all IF/ID fields hold. iFlush does not touch fetch state or hold buffer; only iBrTrue discards.

## Timing
- Reset (iRst high at edge): state=REQ, fetchPc=RESET_PC, kill=0, hold empty, oIF_ID_valid=0, oIF_ID_instr=NOP_INSTR, oIF_ID_pc=0, oIF_ID_pc4=4, oBusy=0; oImemReq=1 with oImemAddr=RESET_PC in the first cycle after reset. Reset mid-request: outstanding response is ignored (kill forced 0, state REQ); memory must be reset together.
- Fetch latency: grant in cycle N, rvalid in N+1 -> instruction visible on oIF_ID_* in N+2.
- Throughput: 1 instruction/cycle with single-cycle memory (issue-on-retire); 1 per (latency+1) otherwise.
- Redirect in cycle N: first request to target issued cycle N+1 (or later if a killed response is pending).
- Outputs oIF_ID_*, oBusy registered; oImemReq/oImemAddr combinational from state, fetchPc, iBrTrue, iImemRvalid, iStall.

## Test plan
- Reset, single-cycle memory returning addr as data -> IF/ID shows pc 0,4,8,12 on consecutive cycles, instr equal to pc, valid=1 from cycle 2.
- 3-cycle latency memory -> new IF/ID instruction every 4 cycles, oBusy high 3 of 4 cycles, oImemReq never high while oBusy without rvalid.
- iStall high for 5 cycles as response for pc 0x10 arrives -> state HOLD, no requests, IF/ID holds previous; on release pc 0x10 delivered next cycle, then 0x14 requested.
- iBrTrue with target 0x203 while request for 0x8 outstanding -> response for 0x8 dropped, next request addr 0x200, IF/ID never shows pc 0x8.
- iFlush and iStall together -> oIF_ID_valid=0, instr=0x00000013; fetch continues unaffected.
- fetchPc at 0xFFFF_FFFC granted -> next request address 0x0000_0000; iRst mid-WAIT -> next cycle request to RESET_PC, IF/ID invalid.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request outstanding to instruction
// memory, fills the IF/ID register, and parks a response that arrives during a stall.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iStall,
  input  logic            iFlush,
  input  logic            iBrTrue,
  input  logic [XLEN-1:0] iBrTarget,
  output logic            oImemReq,
  output logic [XLEN-1:0] oImemAddr,
  input  logic            iImemGnt,
  input  logic            iImemRvalid,
  input  logic [31:0]     iImemRdata,
  output logic            oIF_ID_valid,
  output logic [XLEN-1:0] oIF_ID_pc,
  output logic [XLEN-1:0] oIF_ID_pc4,
  output logic [31:0]     oIF_ID_instr,
  output logic            oBusy
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e          stateQ, stateD;
  logic [XLEN-1:0] fetchPcQ, reqPcQ, holdPcQ;
  logic [31:0]     holdInstrQ;
  logic            killQ;
  logic            grant, respLive, deliverMem, deliverHold;
  logic            unusedTgtBits;

  assign unusedTgtBits = ^iBrTarget[1:0];

  // A live response is one that was neither killed earlier nor dropped by a redirect now.
  assign respLive    = (stateQ == StWait) && iImemRvalid && !killQ && !iBrTrue;
  assign deliverMem  = respLive && !iStall;
  assign deliverHold = (stateQ == StHold) && !iStall && !iBrTrue;

  always_comb begin
    oImemReq = !iBrTrue &&
               ((stateQ == StReq) ||
                ((stateQ == StWait) && iImemRvalid && !killQ && !iStall));
  end

  assign oImemAddr = fetchPcQ;
  assign grant     = oImemReq && iImemGnt;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StReq: begin
        if (grant) stateD = StWait;
      end
      StWait: begin
        if (iBrTrue) begin
          stateD = iImemRvalid ? StReq : StWait;
        end else if (iImemRvalid) begin
          if (killQ)       stateD = StReq;
          else if (iStall) stateD = StHold;
          else             stateD = grant ? StWait : StReq;
        end
      end
      StHold: begin
        if (iBrTrue || !iStall) stateD = StReq;
      end
      default: stateD = StReq;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ       <= StReq;
      fetchPcQ     <= RESET_PC;
      reqPcQ       <= '0;
      killQ        <= 1'b0;
      holdPcQ      <= '0;
      holdInstrQ   <= NOP_INSTR;
      oBusy        <= 1'b0;
      oIF_ID_valid <= 1'b0;
      oIF_ID_pc    <= '0;
      oIF_ID_pc4   <= XLEN'(4);
      oIF_ID_instr <= NOP_INSTR;
    end else begin
      stateQ <= stateD;
      oBusy  <= (stateD == StWait);

      if (iBrTrue)    fetchPcQ <= {iBrTarget[XLEN-1:2], 2'b00};
      else if (grant) fetchPcQ <= fetchPcQ + XLEN'(4);
      if (grant) reqPcQ <= fetchPcQ;

      // A redirect with a request still in flight must swallow that response later.
      if (iBrTrue && (stateQ == StWait) && !iImemRvalid) killQ <= 1'b1;
      else if ((stateQ == StWait) && iImemRvalid)        killQ <= 1'b0;

      if (respLive && iStall) begin
        holdPcQ    <= reqPcQ;
        holdInstrQ <= iImemRdata;
      end

      if (iFlush) begin
        oIF_ID_valid <= 1'b0;
        oIF_ID_instr <= NOP_INSTR;
      end else if (!iStall) begin
        if (deliverMem) begin
          oIF_ID_valid <= 1'b1;
          oIF_ID_pc    <= reqPcQ;
          oIF_ID_pc4   <= reqPcQ + XLEN'(4);
          oIF_ID_instr <= iImemRdata;
        end else if (deliverHold) begin
          oIF_ID_valid <= 1'b1;
          oIF_ID_pc    <= holdPcQ;
          oIF_ID_pc4   <= holdPcQ + XLEN'(4);
          oIF_ID_instr <= holdInstrQ;
        end else begin
          oIF_ID_valid <= 1'b0;
          oIF_ID_instr <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable memory returns each address as data, and a
// queue of expected PCs is checked against every fresh IF/ID delivery.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        brTrue = 1'b0;
  logic [31:0] brTarget = '0;
  logic        imemReq, imemGnt, imemRvalid;
  logic [31:0] imemAddr, imemRdata;
  logic        ifValid, busy;
  logic [31:0] ifPc, ifPc4, ifInstr;

  always #5 clk = ~clk;

  fetch_unit dut (
    .iClk         (clk),
    .iRst         (rst),
    .iStall       (stall),
    .iFlush       (flush),
    .iBrTrue      (brTrue),
    .iBrTarget    (brTarget),
    .oImemReq     (imemReq),
    .oImemAddr    (imemAddr),
    .iImemGnt     (imemGnt),
    .iImemRvalid  (imemRvalid),
    .iImemRdata   (imemRdata),
    .oIF_ID_valid (ifValid),
    .oIF_ID_pc    (ifPc),
    .oIF_ID_pc4   (ifPc4),
    .oIF_ID_instr (ifInstr),
    .oBusy        (busy)
  );

  int unsigned nChecks = 0;
  int unsigned nPass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
    else nPass++;
  endtask

  // Memory: response `lat` cycles after grant. Single-cycle memory is pipelined; slower
  // memory only accepts a new request once idle.
  int unsigned lat = 1;
  int unsigned grantBudget = 0;
  int unsigned grantsDone = 0;
  int unsigned cnt = 0;
  logic        pending = 1'b0;
  logic [31:0] memAddr = '0;

  assign imemRvalid = pending && (cnt == 0);
  assign imemRdata  = memAddr;
  assign imemGnt    = (grantsDone < grantBudget) && (!pending || (imemRvalid && lat == 1));

  always @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      cnt     <= 0;
    end else if (imemReq && imemGnt) begin
      pending    <= 1'b1;
      cnt        <= lat - 1;
      memAddr    <= imemAddr;
      grantsDone <= grantsDone + 1;
    end else if (imemRvalid) begin
      pending <= 1'b0;
    end else if (pending) begin
      cnt <= cnt - 1;
    end
  end

  // Scoreboard: a valid IF/ID after an edge with no stall/flush/reset is a new delivery.
  logic [31:0] sbQ[$];
  logic        lastHold = 1'b1;
  int unsigned reqViol = 0;

  always @(posedge clk) lastHold <= rst || stall || flush;

  always @(negedge clk) begin
    if (busy && !imemRvalid && imemReq) reqViol <= reqViol + 1;
    if (!lastHold && ifValid) begin
      check("sbPending", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        check("sbPc", ifPc, sbQ[0]);
        check("sbPc4", ifPc4, sbQ[0] + 32'd4);
        check("sbInstr", ifInstr, sbQ[0]);
        sbQ.delete(0);
      end
    end
  end

  task automatic resetDut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int busyCnt;

  initial begin
    // Reset and single-cycle streaming
    lat = 1;
    grantBudget = grantsDone + 4;
    sbQ.push_back(32'h0); sbQ.push_back(32'h4); sbQ.push_back(32'h8); sbQ.push_back(32'hC);
    resetDut();
    check("rstValid", 32'(ifValid), 32'd0);
    check("rstInstr", ifInstr, 32'h0000_0013);
    check("rstPc", ifPc, 32'h0);
    check("rstPc4", ifPc4, 32'h4);
    check("rstBusy", 32'(busy), 32'd0);
    check("rstReq", 32'(imemReq), 32'd1);
    check("rstAddr", imemAddr, 32'h0);
    @(negedge clk);
    check("c1Valid", 32'(ifValid), 32'd0);
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      check("streamValid", 32'(ifValid), 32'd1);
      check("streamPc", ifPc, 32'(4 * (k - 2)));
    end

    // Three-cycle memory: one delivery every four cycles
    lat = 3;
    grantBudget = grantsDone + 3;
    sbQ.push_back(32'h10); sbQ.push_back(32'h14); sbQ.push_back(32'h18);
    busyCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      busyCnt += int'(busy);
      if (i == 3) check("latPc10", ifPc, 32'h10);
      if (i == 6) check("latStill10", ifPc, 32'h10);
      if (i == 7) check("latPc14", ifPc, 32'h14);
    end
    check("latBusyCnt", 32'(busyCnt), 32'd9);
    check("latPc18", ifPc, 32'h18);

    // Stall while the response for 0x10 arrives
    lat = 1;
    grantBudget = grantsDone + 6;
    for (int i = 0; i < 6; i++) sbQ.push_back(32'(4 * i));
    resetDut();
    repeat (5) @(negedge clk);
    check("preStallPc", ifPc, 32'hC);
    stall = 1'b1;
    #1 check("stallNoReq", 32'(imemReq), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("holdNoReq", 32'(imemReq), 32'd0);
      check("holdNotBusy", 32'(busy), 32'd0);
      check("holdIfPc", ifPc, 32'hC);
    end
    @(negedge clk);
    stall = 1'b0;
    #1 check("releaseNoReq", 32'(imemReq), 32'd0);
    @(negedge clk);
    check("releasePc", ifPc, 32'h10);
    check("releaseValid", 32'(ifValid), 32'd1);
    check("nextReqAddr", imemAddr, 32'h14);
    check("nextReq", 32'(imemReq), 32'd1);
    repeat (2) @(negedge clk);

    // Redirect while the request for 0x8 is outstanding
    lat = 2;
    grantBudget = grantsDone + 4;
    sbQ.push_back(32'h0); sbQ.push_back(32'h4); sbQ.push_back(32'h200);
    resetDut();
    repeat (7) @(negedge clk);
    check("brBusy", 32'(busy), 32'd1);
    brTrue = 1'b1;
    brTarget = 32'h203;
    #1 check("brNoReq", 32'(imemReq), 32'd0);
    @(negedge clk);
    brTrue = 1'b0;
    #1 check("killNoReq", 32'(imemReq), 32'd0);
    @(negedge clk);
    check("brReq", 32'(imemReq), 32'd1);
    check("brAddr", imemAddr, 32'h200);
    repeat (3) @(negedge clk);
    check("brPc", ifPc, 32'h200);

    // Flush together with stall
    lat = 1;
    grantBudget = grantsDone + 1;
    sbQ.push_back(32'h204);
    flush = 1'b1;
    stall = 1'b1;
    #1 check("flushReq", 32'(imemReq), 32'd1);
    check("flushAddr", imemAddr, 32'h204);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    check("flushValid", 32'(ifValid), 32'd0);
    check("flushInstr", ifInstr, 32'h0000_0013);
    check("flushPcHold", ifPc, 32'h200);
    check("flushPc4Hold", ifPc4, 32'h204);
    check("flushBusy", 32'(busy), 32'd1);
    @(negedge clk);
    check("postFlushPc", ifPc, 32'h204);

    // Address wrap at the top of memory
    brTrue = 1'b1;
    brTarget = 32'hFFFF_FFFF;
    #1 check("wrapBrNoReq", 32'(imemReq), 32'd0);
    @(negedge clk);
    brTrue = 1'b0;
    grantBudget = grantsDone + 2;
    sbQ.push_back(32'hFFFF_FFFC); sbQ.push_back(32'h0);
    #1 check("wrapAddrTop", imemAddr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrapAddrZero", imemAddr, 32'h0);
    check("wrapReq", 32'(imemReq), 32'd1);
    @(negedge clk);
    check("wrapIfPc", ifPc, 32'hFFFF_FFFC);
    check("wrapIfPc4", ifPc4, 32'h0);
    @(negedge clk);

    // Reset while a request is outstanding
    lat = 3;
    grantBudget = grantsDone + 1;
    @(negedge clk);
    check("midWaitBusy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midRstReq", 32'(imemReq), 32'd1);
    check("midRstAddr", imemAddr, 32'h0);
    check("midRstValid", 32'(ifValid), 32'd0);
    check("midRstBusy", 32'(busy), 32'd0);
    lat = 1;
    grantBudget = grantsDone + 1;
    sbQ.push_back(32'h0);
    repeat (2) @(negedge clk);
    check("midRstPc", ifPc, 32'h0);
    check("midRstValid2", 32'(ifValid), 32'd1);
    repeat (3) @(negedge clk);

    check("sbDrain", 32'(sbQ.size()), 32'd0);
    check("reqWhileWait", reqViol, 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
